// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_detect_pkg;

    localparam int unsigned DEF_PAT_W   = 8;
    localparam logic [7:0]  DEF_RST_PAT = 8'b0000_0101;
    localparam int unsigned DEF_RST_LEN = 3;

    // Limit a requested pattern length to the hardware maximum.
    function automatic int unsigned clamp_len(input int unsigned req_len,
                                              input int unsigned max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial input, pattern control and match status bundle of the detector.
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1),
    parameter int unsigned CNT_W = 8
);
    logic             ena;
    logic             input_bit;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] pat_len;
    logic             cnt_clr;
    logic             output_indicator;
    logic [LEN_W-1:0] present_state;
    logic [CNT_W-1:0] match_count;

    modport master (
        output ena, input_bit, overlap, pat_load, pat_in, pat_len, cnt_clr,
        input  output_indicator, present_state, match_count
    );

    modport slave (
        input  ena, input_bit, overlap, pat_load, pat_in, pat_len, cnt_clr,
        output output_indicator, present_state, match_count
    );
endinterface

// File: rtl/seq_detect_param_match_cnt.sv
// Saturating match counter; clear coinciding with a match restarts at one.
module seq_match_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count matches, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time loadable serial pattern detector with overlap control.
// Optional match counter compiled in when SEQ_DETECT_COUNT_EN is defined.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter int unsigned      LEN_W   = $clog2(PAT_W + 1),
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int unsigned      RST_LEN = DEF_RST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             oi_q,   oi_d;
    logic [PAT_W-1:0] shift_c;
    logic [PAT_W-1:0] mask_c;
    logic [LEN_W-1:0] fill_inc_c;
    logic             match_c;
    logic             unused_hist_msb;

    assign shift_c         = {hist_q[PAT_W-2:0], bus.input_bit};
    assign fill_inc_c      = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    assign unused_hist_msb = hist_q[PAT_W-1];

    // Select the low len bits for the pattern compare.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask_c[i] = (i < int'(len_q));
        end
    end

    // Next-state: load wins over sampling; a match resets fill unless overlapping.
    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        oi_d    = 1'b0;
        match_c = 1'b0;
        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            len_d  = LEN_W'(clamp_len(32'(bus.pat_len), PAT_W));
            hist_d = '0;
            fill_d = '0;
        end else if (bus.ena) begin
            hist_d  = shift_c;
            fill_d  = fill_inc_c;
            match_c = (len_q != '0) && (fill_inc_c == len_q) &&
                      (((shift_c ^ pat_q) & mask_c) == '0);
            if (match_c) begin
                oi_d   = 1'b1;
                fill_d = bus.overlap ? len_q : '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= RST_PAT;
            len_q  <= LEN_W'(RST_LEN);
            fill_q <= '0;
            oi_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            fill_q <= fill_d;
            oi_q   <= oi_d;
        end
    end

    assign bus.output_indicator = oi_q;
    assign bus.present_state    = fill_q;

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] count_q;

    seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_c),
        .clr   (bus.cnt_clr),
        .count (count_q)
    );

    assign bus.match_count = count_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param; drives an 8-bit and a 2-bit counter instance.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int oi;
        int fill;
        int c8;
        int c2;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   pulses;
    bit   ov;
    exp_t sb[$];

    logic [7:0] mhist;
    logic [7:0] mpat;
    int         mlen;
    int         mfill;
    int         mc8;
    int         mc2;

    seq_detect_param_if #(.PAT_W(8), .CNT_W(8)) bus8 ();
    seq_detect_param_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

    seq_detect_param #(.PAT_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mhist = '0;
        mpat  = 8'b0000_0101;
        mlen  = 3;
        mfill = 0;
        mc8   = 0;
        mc2   = 0;
    endtask

    task automatic model_step(input bit e, input bit b, input bit ld,
                              input logic [7:0] p, input logic [3:0] l, input bit clr);
        bit   hit;
        int   nf;
        exp_t x;
        hit = 1'b0;
        if (ld) begin
            mpat  = p;
            mlen  = (int'(l) > 8) ? 8 : int'(l);
            mhist = '0;
            mfill = 0;
        end else if (e) begin
            mhist = {mhist[6:0], b};
            nf    = (mfill < mlen) ? mfill + 1 : mlen;
            hit   = (mlen > 0) && (nf == mlen);
            for (int i = 0; i < mlen; i++) begin
                if (mhist[i] !== mpat[i]) hit = 1'b0;
            end
            mfill = (hit && !ov) ? 0 : nf;
        end
        if (CNT_EN) begin
            if (clr) begin
                mc8 = hit ? 1 : 0;
                mc2 = hit ? 1 : 0;
            end else if (hit) begin
                if (mc8 < 255) mc8++;
                if (mc2 < 3) mc2++;
            end
        end
        x.oi   = hit ? 1 : 0;
        x.fill = mfill;
        x.c8   = mc8;
        x.c2   = mc2;
        sb.push_back(x);
    endtask

    task automatic drive(input bit e, input bit b, input bit ld,
                         input logic [7:0] p, input logic [3:0] l, input bit clr);
        bus8.ena = e; bus8.input_bit = b; bus8.pat_load = ld;
        bus8.pat_in = p; bus8.pat_len = l; bus8.cnt_clr = clr; bus8.overlap = ov;
        bus2.ena = e; bus2.input_bit = b; bus2.pat_load = ld;
        bus2.pat_in = p; bus2.pat_len = l; bus2.cnt_clr = clr; bus2.overlap = ov;
    endtask

    // One clock: drive on the falling edge, compare just after the rising edge.
    task automatic cycle(input bit e, input bit b, input bit ld = 1'b0,
                         input logic [7:0] p = '0, input logic [3:0] l = '0,
                         input bit clr = 1'b0);
        exp_t x;
        @(negedge clk);
        drive(e, b, ld, p, l, clr);
        model_step(e, b, ld, p, l, clr);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check("oi",    32'(bus8.output_indicator), 32'(x.oi));
            check("fill",  32'(bus8.present_state),    32'(x.fill));
            check("cnt8",  32'(bus8.match_count),      32'(x.c8));
            check("oi_2",  32'(bus2.output_indicator), 32'(x.oi));
            check("fill_2", 32'(bus2.present_state),   32'(x.fill));
            check("cnt2",  32'(bus2.match_count),      32'(x.c2));
        end
        if (bus8.output_indicator === 1'b1) pulses++;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Feed n bits, MSB of the used field first.
    task automatic feed(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, t[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oi"},   32'(bus8.output_indicator), 32'd0);
        check({tag, "_fill"}, 32'(bus8.present_state),    32'd0);
        check({tag, "_cnt8"}, 32'(bus8.match_count),      32'd0);
        check({tag, "_cnt2"}, 32'(bus2.match_count),      32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        pulses = 0;
        ov     = 1'b1;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Default "101", overlapping.
        ov = 1'b1; pulses = 0;
        feed(32'b1010101, 7);
        check("s1_pulses", 32'(pulses), 32'd3);
        check("s1_count", 32'(bus8.match_count), CNT_EN ? 32'd3 : 32'd0);

        // Same stream, non-overlapping, after reload and count clear.
        ov = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1);
        pulses = 0;
        feed(32'b1010101, 7);
        check("s2_pulses", 32'(pulses), 32'd2);

        // Full-width pattern with an ena gap in the middle.
        cycle(1'b0, 1'b0, 1'b1, 8'b1100_1011, 4'd8);
        pulses = 0;
        feed(32'b1100, 4);
        repeat (3) cycle(1'b0, 1'b1);
        check("s3_gap_pulses", 32'(pulses), 32'd0);
        feed(32'b1011, 4);
        check("s3_pulses", 32'(pulses), 32'd1);

        // Load mid-stream with a live bit; over-long length clamps to 8.
        feed(32'b11, 2);
        cycle(1'b1, 1'b1, 1'b1, 8'hFF, 4'd12);
        check("load_fill", 32'(bus8.present_state), 32'd0);
        pulses = 0;
        feed(32'hFF, 8);
        check("clamp_pulses", 32'(pulses), 32'd1);

        // Zero length disables detection.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 4'd0);
        pulses = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        check("len0_pulses", 32'(pulses), 32'd0);

        // Pattern "11", overlapping: narrow counter saturates, clear on match gives 1.
        ov = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 8'b11, 4'd2, 1'b1);
        pulses = 0;
        feed(32'b111111, 6);
        check("s5_pulses", 32'(pulses), 32'd5);
        check("s5_sat", 32'(bus2.match_count), CNT_EN ? 32'd3 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
        check("s5_clr_match", 32'(bus2.match_count), CNT_EN ? 32'd1 : 32'd0);

        // Asynchronous reset mid-pattern restores the "101" pattern.
        ov = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 8'b0110, 4'd4);
        feed(32'b01, 2);
        check("pre_rst_fill", 32'(bus8.present_state), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        feed(32'b101, 3);
        check("post_rst_pulses", 32'(pulses), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
